wb_port_arbiter: RTL

- Shares the single register-file write port between two sources: the in-order writeback stage and a multi-cycle mul/div unit.
- Mul/div results are buffered in a small in-order FIFO and drained into idle writeback slots.
- A starvation counter, or a full FIFO, forces a drain, which stalls the pipeline for one cycle.
- Sits between writeback and the register file; its registered outputs drive the register-file write port directly.

---
 rtl/wb_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the register-file write port between the in-order writeback stage
// and a multi-cycle mul/div unit. Mul/div results are queued in a small
// in-order FIFO and drained into idle writeback slots. A starvation counter
// or a full FIFO forces a drain, which stalls the pipeline for one cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_pipe_valid/rd_num/rd   writeback-stage result
//   o_pipe_stall             pipeline must hold its result (combinational)
//   i_md_valid/rd_num/rd     mul/div result offer
//   o_md_ready               FIFO accepts the offer (combinational)
//   o_rf_we/rd_num/rd        registered register-file write port
//   o_md_count               FIFO occupancy
module wb_port_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_pipe_valid,
    input  logic [4:0]             i_pipe_rd_num,
    input  logic [31:0]            i_pipe_rd,
    output logic                   o_pipe_stall,
    input  logic                   i_md_valid,
    input  logic [4:0]             i_md_rd_num,
    input  logic [31:0]            i_md_rd,
    output logic                   o_md_ready,
    output logic                   o_rf_we,
    output logic [4:0]             o_rf_rd_num,
    output logic [31:0]            o_rf_rd,
    output logic [$clog2(DEPTH):0] o_md_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    // FIFO state
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [4:0]        num_mem_q  [DEPTH];
    logic [4:0]        num_mem_d  [DEPTH];
    logic [31:0]       data_mem_q [DEPTH];
    logic [31:0]       data_mem_d [DEPTH];

    // Write-port registers
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_num_q, rf_num_d;
    logic [31:0]       rf_data_q, rf_data_d;

    logic              empty;
    logic              full;
    logic              push;
    logic              drain;

    // Status decode: ready and drain look only at registered occupancy,
    // so a same-cycle pop never opens the FIFO to a push.
    always_comb begin
        empty = (count_q == CNT_W'(0));
        full  = (count_q == CNT_W'(DEPTH));
        drain = !rst && !empty &&
                (!i_pipe_valid || (wait_q == WAIT_W'(MAX_WAIT)) || full);
        push  = i_md_valid && !rst && !full;
    end

    assign o_md_ready   = !rst && !full;
    assign o_pipe_stall = drain && i_pipe_valid;
    assign o_rf_we      = rf_we_q;
    assign o_rf_rd_num  = rf_num_q;
    assign o_rf_rd      = rf_data_q;
    assign o_md_count   = count_q;

    // FIFO push/pop and starvation counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        num_mem_d  = num_mem_q;
        data_mem_d = data_mem_q;
        wait_d     = wait_q;

        if (push) begin
            num_mem_d[wr_ptr_q]  = i_md_rd_num;
            data_mem_d[wr_ptr_q] = i_md_rd;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(drain);

        if (drain || empty) begin
            wait_d = WAIT_W'(0);
        end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Write-port source select; writes to x0 are suppressed but still consume
    always_comb begin
        rf_we_d   = 1'b0;
        rf_num_d  = rf_num_q;
        rf_data_d = rf_data_q;

        if (drain) begin
            rf_we_d   = (num_mem_q[rd_ptr_q] != 5'd0);
            rf_num_d  = num_mem_q[rd_ptr_q];
            rf_data_d = data_mem_q[rd_ptr_q];
        end else if (i_pipe_valid && !rst) begin
            rf_we_d   = (i_pipe_rd_num != 5'd0);
            rf_num_d  = i_pipe_rd_num;
            rf_data_d = i_pipe_rd;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_num_q  <= 5'd0;
            rf_data_q <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            rf_we_q   <= rf_we_d;
            rf_num_q  <= rf_num_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Storage needs no reset: entries are only read when count says valid
    always_ff @(posedge clk) begin
        num_mem_q  <= num_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule
